// File: rtl/float_to_int_converter_pkg.sv
// ----------------------------------------------------------------------------
// float_to_int_pkg
// Shared definitions for the float-to-integer conversion path:
//   - exp_bias()  : IEEE-754 style exponent bias for an E-bit exponent field
//   - CLS_*       : 2-bit classification of a decoded float
//   - flags_t     : exception flag bundle, ordered {invalid, overflow, inexact}
// ----------------------------------------------------------------------------
package float_to_int_pkg;

    localparam logic [1:0] CLS_ZERO   = 2'd0;  // exponent field all zeros (zero or denormal)
    localparam logic [1:0] CLS_NORMAL = 2'd1;
    localparam logic [1:0] CLS_INF    = 2'd2;
    localparam logic [1:0] CLS_NAN    = 2'd3;

    typedef struct packed {
        logic invalid;
        logic overflow;
        logic inexact;
    } flags_t;

    function automatic int exp_bias(input int e_width);
        return (1 << (e_width - 1)) - 1;
    endfunction

endpackage

// File: rtl/float_to_int_converter_if.sv
// ----------------------------------------------------------------------------
// float_to_int_converter_if
// Valid/ready stream bundle around the converter.
//   in_valid/in_ready/in_float          : float input side
//   out_valid/out_ready/out_int/out_*   : integer result side with flags
// Modports:
//   master : the environment (producer of floats, consumer of integers)
//   slave  : the converter
// ----------------------------------------------------------------------------
interface float_to_int_converter_if #(
    parameter int EXPONENT_WIDTH = 8,
    parameter int MANTISSA_WIDTH = 23,
    parameter int INT_WIDTH      = 32
);
    logic                                   in_valid;
    logic                                   in_ready;
    logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0] in_float;
    logic                                   out_valid;
    logic                                   out_ready;
    logic [INT_WIDTH-1:0]                   out_int;
    logic                                   out_invalid;
    logic                                   out_overflow;
    logic                                   out_inexact;

    modport master (
        output in_valid, in_float, out_ready,
        input  in_ready, out_valid, out_int, out_invalid, out_overflow, out_inexact
    );

    modport slave (
        input  in_valid, in_float, out_ready,
        output in_ready, out_valid, out_int, out_invalid, out_overflow, out_inexact
    );
endinterface

// File: rtl/float_to_int_converter_unpack.sv
// ----------------------------------------------------------------------------
// fp_field_unpack (combinational)
// Splits a {sign, exponent, mantissa} float into its fields.
//   fp      : packed float input
//   sign    : sign bit
//   exp_unb : unbiased exponent, signed E+1 bits
//   sig     : significand with hidden one, {1, mantissa}
//   cls     : CLS_ZERO / CLS_NORMAL / CLS_INF / CLS_NAN
// ----------------------------------------------------------------------------
module fp_field_unpack
    import float_to_int_pkg::*;
#(
    parameter int EXPONENT_WIDTH = 8,
    parameter int MANTISSA_WIDTH = 23
) (
    input  logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0] fp,
    output logic                                   sign,
    output logic signed [EXPONENT_WIDTH:0]         exp_unb,
    output logic [MANTISSA_WIDTH:0]                sig,
    output logic [1:0]                             cls
);
    localparam int E = EXPONENT_WIDTH;
    localparam int M = MANTISSA_WIDTH;
    localparam logic [E:0] BIAS_V = (E + 1)'(exp_bias(E));

    logic [E-1:0] exp_field;
    logic [M-1:0] mant;

    assign sign      = fp[E+M];
    assign exp_field = fp[E+M-1:M];
    assign mant      = fp[M-1:0];
    assign exp_unb   = $signed({1'b0, exp_field} - BIAS_V);
    assign sig       = {1'b1, mant};

    // NOTE: every output of a combinational block gets a default first so no
    // path through it leaves the value unassigned (which would infer a latch).
    always_comb begin
        cls = CLS_NORMAL;
        if (exp_field == '0)
            cls = CLS_ZERO;
        else if (exp_field == '1)
            cls = (mant != '0) ? CLS_NAN : CLS_INF;
    end
endmodule

// File: rtl/float_to_int_converter.sv
// ----------------------------------------------------------------------------
// float_to_int_converter
// Two-stage pipelined float -> signed integer conversion, round toward zero,
// saturating, with invalid/overflow/inexact flags.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, drops all in-flight data
//   bus   : slave side of the valid/ready stream interface
// Stage 1 registers the unpacked fields; stage 2 registers the shifted,
// negated or saturated result. The exponent gives the shift directly.
// ----------------------------------------------------------------------------
module float_to_int_converter
    import float_to_int_pkg::*;
#(
    parameter int EXPONENT_WIDTH = 8,
    parameter int MANTISSA_WIDTH = 23,
    parameter int INT_WIDTH      = 32
) (
    input logic                       clk,
    input logic                       rst_n,
    float_to_int_converter_if.slave   bus
);
    localparam int E  = EXPONENT_WIDTH;
    localparam int M  = MANTISSA_WIDTH;
    localparam int W  = INT_WIDTH;
    // Magnitude must hold both the full significand and any in-range integer.
    localparam int MW = (W > M + 1) ? W : M + 1;

    localparam logic [W-1:0] INT_MAX = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] INT_MIN = {1'b1, {(W-1){1'b0}}};

    logic                 u_sign;
    logic signed [E:0]    u_exp;
    logic [M:0]           u_sig;
    logic [1:0]           u_cls;

    fp_field_unpack #(
        .EXPONENT_WIDTH (E),
        .MANTISSA_WIDTH (M)
    ) u_unpack (
        .fp      (bus.in_float),
        .sign    (u_sign),
        .exp_unb (u_exp),
        .sig     (u_sig),
        .cls     (u_cls)
    );

    logic                 s1_valid;
    logic                 s1_sign;
    logic signed [E:0]    s1_exp;
    logic [M:0]           s1_sig;
    logic [1:0]           s1_cls;
    logic                 s2_valid;

    logic accept;
    logic s1_move;

    // Stage 1 can take a new float whenever its current content can move on.
    assign bus.in_ready  = !s1_valid || !s2_valid || bus.out_ready;
    assign accept        = bus.in_valid && bus.in_ready;
    assign s1_move       = s1_valid && (!s2_valid || bus.out_ready);
    assign bus.out_valid = s2_valid;

    // Stage-2 combinational conversion from the stage-1 registers.
    int           e_int;
    int           lsh;
    int           rsh;
    logic         frac_nz;
    logic [MW-1:0] sig_ext;
    logic [MW-1:0] mag;
    logic [W-1:0] res;
    flags_t       flg;

    always_comb begin
        e_int   = int'(s1_exp);
        frac_nz = |s1_sig[M-1:0];
        sig_ext = MW'(s1_sig);
        lsh     = 0;
        rsh     = 0;
        mag     = '0;
        res     = '0;
        flg     = '0;
        unique case (s1_cls)
            CLS_ZERO: flg.inexact = frac_nz;   // denormals flush to zero
            CLS_NAN: begin
                res         = INT_MAX;
                flg.invalid = 1'b1;
            end
            CLS_INF: begin
                res          = s1_sign ? INT_MIN : INT_MAX;
                flg.overflow = 1'b1;
            end
            default: begin
                if (e_int < 0) begin
                    flg.inexact = 1'b1;
                end else if (e_int <= W - 2) begin
                    // Shift amounts are clamped below MW for any E/M/W mix.
                    if (e_int >= M) begin
                        lsh = (e_int - M > MW - 1) ? MW - 1 : e_int - M;
                        mag = sig_ext << lsh;
                    end else begin
                        rsh = (M - e_int > MW - 1) ? MW - 1 : M - e_int;
                        mag = sig_ext >> rsh;
                        flg.inexact = |(sig_ext & ~({MW{1'b1}} << rsh));
                    end
                    res = s1_sign ? -mag[W-1:0] : mag[W-1:0];
                end else if (e_int == W - 1 && s1_sign && !frac_nz) begin
                    res = INT_MIN;                  // exactly -2^(W-1)
                end else begin
                    res          = s1_sign ? INT_MIN : INT_MAX;
                    flg.overflow = 1'b1;
                end
            end
        endcase
    end

    // NOTE: sequential state is written only with non-blocking assignments so
    // every register samples pre-edge values and stage order cannot race.
    // NOTE: the data registers are reset along with the valids so out_int and
    // the flags read zero after reset rather than stale values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid         <= 1'b0;
            s1_sign          <= 1'b0;
            s1_exp           <= '0;
            s1_sig           <= '0;
            s1_cls           <= CLS_ZERO;
            s2_valid         <= 1'b0;
            bus.out_int      <= '0;
            bus.out_invalid  <= 1'b0;
            bus.out_overflow <= 1'b0;
            bus.out_inexact  <= 1'b0;
        end else begin
            if (accept) begin
                s1_valid <= 1'b1;
                s1_sign  <= u_sign;
                s1_exp   <= u_exp;
                s1_sig   <= u_sig;
                s1_cls   <= u_cls;
            end else if (s1_move) begin
                s1_valid <= 1'b0;
            end

            if (s1_move) begin
                s2_valid         <= 1'b1;
                bus.out_int      <= res;
                bus.out_invalid  <= flg.invalid;
                bus.out_overflow <= flg.overflow;
                bus.out_inexact  <= flg.inexact;
            end else if (bus.out_ready) begin
                s2_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_float_to_int_converter.sv
// ----------------------------------------------------------------------------
// tb_float_to_int_converter
// Self-checking bench for float_to_int_converter (E=8, M=23, W=32): directed
// vector table, backpressure and reset sequences, and a randomized stream
// scored against an arithmetic reference model.
// ----------------------------------------------------------------------------
module tb_float_to_int_converter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    float_to_int_converter_if #(
        .EXPONENT_WIDTH (8),
        .MANTISSA_WIDTH (23),
        .INT_WIDTH      (32)
    ) bus ();

    float_to_int_converter #(
        .EXPONENT_WIDTH (8),
        .MANTISSA_WIDTH (23),
        .INT_WIDTH      (32)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [31:0] f;
        logic [31:0] want_int;
        logic [2:0]  want_flags;   // {invalid, overflow, inexact}
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, want);
        end
    endtask

    function automatic logic [34:0] get_out();
        return {bus.out_int, bus.out_invalid, bus.out_overflow, bus.out_inexact};
    endfunction

    // Reference: value = (-1)^s * 1.mant * 2^e truncated toward zero, then
    // range-checked against the 32-bit signed range.
    function automatic logic [34:0] model(input logic [31:0] f);
        logic       s;
        int         ex;
        int         e;
        longint     sig;
        longint     scaled;
        longint     t;
        longint     v;
        logic       inx;
        s  = f[31];
        ex = int'(f[30:23]);
        if (ex == 0)
            return {32'h0, 2'b00, (f[22:0] != 0)};
        if (ex == 255) begin
            if (f[22:0] != 0) return {32'h7FFF_FFFF, 3'b100};
            return {(s ? 32'h8000_0000 : 32'h7FFF_FFFF), 3'b010};
        end
        e   = ex - 127;
        sig = longint'({1'b1, f[22:0]});
        if (e < 0)
            return {32'h0, 3'b001};
        if (e > 32)
            return {(s ? 32'h8000_0000 : 32'h7FFF_FFFF), 3'b010};
        scaled = sig << e;
        t      = scaled >>> 23;
        inx    = (scaled & ((longint'(1) << 23) - 1)) != 0;
        v      = s ? -t : t;
        if (v > longint'(32'h7FFF_FFFF) || v < -(longint'(1) << 31))
            return {(s ? 32'h8000_0000 : 32'h7FFF_FFFF), 3'b010};
        return {v[31:0], 2'b00, inx};
    endfunction

    function automatic logic [31:0] rand_float();
        logic [7:0]  ex;
        logic [22:0] man;
        int          sel;
        sel = int'($urandom_range(0, 9));
        man = 23'($urandom);
        if (sel == 0)      ex = 8'h00;
        else if (sel == 1) begin
            ex = 8'hFF;
            if ($urandom_range(0, 1) == 0) man = '0;
        end else           ex = 8'($urandom_range(110, 162));
        return {1'($urandom), ex, man};
    endfunction

    // Single transfer from a negedge: accepted at the next rising edge,
    // result visible after the second rising edge.
    task automatic run_one(input logic [31:0] f, input string name, input logic [34:0] want);
        bus.in_valid  = 1'b1;
        bus.in_float  = f;
        bus.out_ready = 1'b1;
        #1;
        check({name, "_in_ready"}, 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check({name, "_not_early"}, 64'(bus.out_valid), 64'd0);
        @(posedge clk);
        @(negedge clk);
        check({name, "_valid"}, 64'(bus.out_valid), 64'd1);
        check(name, 64'(get_out()), 64'(want));
    endtask

    task automatic idle_cycle();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
    endtask

    vec_t vecs[$];

    initial begin
        logic [34:0] q[$];
        logic [34:0] exp_a;
        logic [34:0] exp_b;
        logic [34:0] exp_c;
        logic        in_taken;
        int          sent;
        int          got;
        int          cycles;

        bus.in_valid  = 1'b0;
        bus.in_float  = '0;
        bus.out_ready = 1'b1;

        vecs.push_back('{32'h3FC0_0000, 32'h0000_0001, 3'b001}); // 1.5
        vecs.push_back('{32'hC2F6_0000, 32'hFFFF_FF85, 3'b000}); // -123
        vecs.push_back('{32'h0000_0000, 32'h0000_0000, 3'b000}); // +0
        vecs.push_back('{32'h8000_0000, 32'h0000_0000, 3'b000}); // -0
        vecs.push_back('{32'h0000_0001, 32'h0000_0000, 3'b001}); // denormal
        vecs.push_back('{32'h4F00_0000, 32'h7FFF_FFFF, 3'b010}); // 2^31
        vecs.push_back('{32'hCF00_0000, 32'h8000_0000, 3'b000}); // -2^31
        vecs.push_back('{32'hCF00_0001, 32'h8000_0000, 3'b010}); // just below -2^31
        vecs.push_back('{32'h4EFF_FFFF, 32'h7FFF_FF80, 3'b000}); // largest below 2^31
        vecs.push_back('{32'hFF80_0000, 32'h8000_0000, 3'b010}); // -inf
        vecs.push_back('{32'h7F80_0000, 32'h7FFF_FFFF, 3'b010}); // +inf
        vecs.push_back('{32'h7FC0_0000, 32'h7FFF_FFFF, 3'b100}); // NaN
        vecs.push_back('{32'hFFC0_0001, 32'h7FFF_FFFF, 3'b100}); // -NaN
        vecs.push_back('{32'h3F80_0000, 32'h0000_0001, 3'b000}); // 1.0
        vecs.push_back('{32'hBFC0_0000, 32'hFFFF_FFFF, 3'b001}); // -1.5
        vecs.push_back('{32'h3F00_0000, 32'h0000_0000, 3'b001}); // 0.5
        vecs.push_back('{32'h4B00_0001, 32'h0080_0001, 3'b000}); // 2^23+1
        vecs.push_back('{32'h4A80_0001, 32'h0040_0000, 3'b001}); // 2^22+0.5
        vecs.push_back('{32'h501502F9, 32'h7FFF_FFFF, 3'b010}); // 1e10

        // Reset state
        #3;
        check("reset_out_valid", 64'(bus.out_valid), 64'd0);
        check("reset_in_ready", 64'(bus.in_ready), 64'd1);
        check("reset_out", 64'(get_out()), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vecs[i])
            run_one(vecs[i].f, $sformatf("vec%0d_%h", i, vecs[i].f),
                    {vecs[i].want_int, vecs[i].want_flags});
        idle_cycle();

        // Backpressure: two inputs fill the pipe, the third is refused.
        exp_a = model(32'h3FC0_0000);
        exp_b = model(32'hC2F6_0000);
        exp_c = model(32'h4F00_0000);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_float  = 32'h3FC0_0000;
        #1 check("bp_ready_a", 64'(bus.in_ready), 64'd1);
        @(posedge clk); @(negedge clk);
        bus.in_float = 32'hC2F6_0000;
        #1 check("bp_ready_b", 64'(bus.in_ready), 64'd1);
        @(posedge clk); @(negedge clk);
        bus.in_float = 32'h4F00_0000;
        #1 check("bp_ready_c", 64'(bus.in_ready), 64'd0);
        check("bp_out_a", 64'(get_out()), 64'(exp_a));
        @(posedge clk); @(negedge clk);
        check("bp_hold_valid", 64'(bus.out_valid), 64'd1);
        check("bp_hold_a", 64'(get_out()), 64'(exp_a));
        check("bp_still_full", 64'(bus.in_ready), 64'd0);
        bus.out_ready = 1'b1;
        #1 check("bp_ready_release", 64'(bus.in_ready), 64'd1);
        @(posedge clk); @(negedge clk);
        bus.in_valid = 1'b0;
        check("bp_out_b", 64'(get_out()), 64'(exp_b));
        @(posedge clk); @(negedge clk);
        check("bp_valid_c", 64'(bus.out_valid), 64'd1);
        check("bp_out_c", 64'(get_out()), 64'(exp_c));
        @(posedge clk); @(negedge clk);
        check("bp_drained", 64'(bus.out_valid), 64'd0);

        // Randomized stream with random in_valid / out_ready.
        sent = 0; got = 0; cycles = 0; in_taken = 1'b0;
        while ((sent < 100 || q.size() > 0) && cycles < 3000) begin
            @(negedge clk);
            cycles++;
            if (in_taken) bus.in_valid = 1'b0;
            if (!bus.in_valid && sent < 100 && $urandom_range(0, 3) != 0) begin
                bus.in_valid = 1'b1;
                bus.in_float = rand_float();
            end
            bus.out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (bus.out_valid && bus.out_ready) begin
                check("stream_nonempty", 64'(q.size() != 0), 64'd1);
                if (q.size() != 0)
                    check($sformatf("stream_%0d", got), 64'(get_out()), 64'(q.pop_front()));
                got++;
            end
            in_taken = bus.in_valid && bus.in_ready;
            if (in_taken) begin
                q.push_back(model(bus.in_float));
                sent++;
            end
        end
        check("stream_count", 64'(got), 64'd100);
        check("stream_in_budget", 64'(cycles < 3000), 64'd1);
        @(negedge clk);
        idle_cycle();

        // Reset with both stages full.
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_float  = 32'h4E80_0000;
        @(posedge clk); @(negedge clk);
        bus.in_float  = 32'hC2F6_0000;
        @(posedge clk); @(negedge clk);
        bus.in_valid = 1'b0;
        check("rst_full_valid", 64'(bus.out_valid), 64'd1);
        check("rst_full_ready", 64'(bus.in_ready), 64'd0);
        #1 rst_n = 1'b0;
        #1;
        check("rst_async_valid", 64'(bus.out_valid), 64'd0);
        check("rst_async_ready", 64'(bus.in_ready), 64'd1);
        check("rst_async_out", 64'(get_out()), 64'd0);
        #1 rst_n = 1'b1;
        @(negedge clk);
        run_one(32'h4E80_0000, "post_reset", model(32'h4E80_0000));
        idle_cycle();
        check("post_reset_empty", 64'(bus.out_valid), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
